// File: rtl/synth_pkg.sv
// synth_pkg: shared waveform codes and default oscillator widths
package synth_pkg;
  typedef enum logic [1:0] {
    WAVE_SQUARE   = 2'b00,
    WAVE_TRIANGLE = 2'b01,
    WAVE_SAWTOOTH = 2'b10,
    WAVE_RSVD     = 2'b11
  } wave_e;
  localparam int PHASE_W_DEF = 24;
  localparam int OUT_W_DEF   = 12;
endpackage

// File: rtl/wave_shaper.sv
// wave_shaper: maps (waveform code, phase) to an unsigned sample
module wave_shaper
  import synth_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int OUT_W   = OUT_W_DEF
) (
  input  logic [1:0]         wave_i,
  input  logic [PHASE_W-1:0] phase_i,
  output logic [OUT_W-1:0]   shape_o
);
  logic             m;
  logic [OUT_W-1:0] top;
  logic [OUT_W-1:0] r;
  assign m   = phase_i[PHASE_W-1];
  assign top = phase_i[PHASE_W-1 -: OUT_W];
  assign r   = phase_i[PHASE_W-2 -: OUT_W];
  // triangle folds the second half of the period; reserved code parks at mid-scale
  always_comb
    shape_o = (wave_i == WAVE_SQUARE)   ? (m ? '0 : '1) :
              (wave_i == WAVE_TRIANGLE) ? (m ? ~r : r) :
              (wave_i == WAVE_SAWTOOTH) ? top :
              {1'b1, {(OUT_W-1){1'b0}}};
endmodule

// File: rtl/wave_osc.sv
// wave_osc: phase-accumulator oscillator; WAVE_SYNC_SWITCH_EN defers waveform switches to the period wrap
module wave_osc
  import synth_pkg::*;
#(
  parameter int PHASE_W = PHASE_W_DEF,
  parameter int OUT_W   = OUT_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic [1:0]         waveform_in,
  input  logic [PHASE_W-1:0] phase_inc,
  input  logic               sample_tick,
  input  logic               phase_rst,
  output logic [OUT_W-1:0]   sample_out,
  output logic               sample_valid,
  output logic               wrap
);
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [OUT_W-1:0]   sample_q, sample_d, shape;
  logic               valid_q, valid_d, wrap_q, wrap_d;
  logic [PHASE_W:0]   sum;
  logic               tick, sync;
  logic [1:0]         wave_act;
  assign sum  = {1'b0, phase_q} + {1'b0, phase_inc};
  assign sync = ena & phase_rst;
  assign tick = ena & sample_tick & ~phase_rst;
`ifdef WAVE_SYNC_SWITCH_EN
  logic [1:0] wave_q, wave_d;
  // waveform latches only at a period boundary or hard sync
  always_comb wave_d = (sync | (tick & sum[PHASE_W])) ? waveform_in : wave_q;
  // active waveform register
  always_ff @(posedge clk or posedge rst)
    if (rst) wave_q <= WAVE_SQUARE;
    else wave_q <= wave_d;
  assign wave_act = wave_q;
`else
  assign wave_act = waveform_in;
`endif
  wave_shaper #(.PHASE_W(PHASE_W), .OUT_W(OUT_W)) u_shaper (
    .wave_i (wave_act),
    .phase_i(phase_q),
    .shape_o(shape)
  );
  // sample uses the pre-increment phase; hard sync wins over a coincident tick
  always_comb begin
    phase_d  = sync ? '0 : tick ? sum[PHASE_W-1:0] : phase_q;
    sample_d = tick ? shape : sample_q;
    valid_d  = tick;
    wrap_d   = tick & sum[PHASE_W];
  end
  // accumulator and output registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      phase_q  <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      wrap_q   <= wrap_d;
    end
  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign wrap         = wrap_q;
endmodule

// File: tb/tb_wave_osc.sv
// tb_wave_osc: directed and randomized checks of wave_osc against an arithmetic reference model
module tb_wave_osc;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b0;
  logic [1:0]  waveform_in = 2'b00;
  logic [23:0] phase_inc = '0;
  logic        sample_tick = 1'b0;
  logic        phase_rst = 1'b0;
  logic [11:0] sample_out;
  logic        sample_valid;
  logic        wrap;
  int checks = 0;
  int failures = 0;
  longint m_phase = 0;
  int m_sample = 0;
  int m_valid = 0;
  int m_wrap = 0;
  int m_wave = 0;
  always #5 clk = ~clk;
  wave_osc dut (
    .clk(clk), .rst(rst), .ena(ena), .waveform_in(waveform_in),
    .phase_inc(phase_inc), .sample_tick(sample_tick), .phase_rst(phase_rst),
    .sample_out(sample_out), .sample_valid(sample_valid), .wrap(wrap)
  );
  function automatic int shape(input int w, input longint ph);
    int f;
    f = int'((ph / 2048) % 4096);
    case (w)
      0: return (ph < 64'd8388608) ? 4095 : 0;
      1: return (ph < 64'd8388608) ? f : 4095 - f;
      2: return int'(ph / 4096);
      default: return 2048;
    endcase
  endfunction
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask
  task automatic model(input logic e, input logic t, input logic p);
    longint s;
    int aw;
    if (e && p) begin
      m_phase = 0;
      m_valid = 0;
      m_wrap = 0;
`ifdef WAVE_SYNC_SWITCH_EN
      m_wave = int'(waveform_in);
`endif
    end else if (e && t) begin
`ifdef WAVE_SYNC_SWITCH_EN
      aw = m_wave;
`else
      aw = int'(waveform_in);
`endif
      m_sample = shape(aw, m_phase);
      s = m_phase + longint'(phase_inc);
      m_wrap = (s >= 64'd16777216) ? 1 : 0;
      m_phase = s % 64'd16777216;
      m_valid = 1;
`ifdef WAVE_SYNC_SWITCH_EN
      if (m_wrap == 1) m_wave = int'(waveform_in);
`endif
    end else begin
      m_valid = 0;
      m_wrap = 0;
    end
  endtask
  task automatic step(input logic e, input logic t, input logic p);
    ena = e;
    sample_tick = t;
    phase_rst = p;
    @(posedge clk);
    #1;
    model(e, t, p);
    check("sample_out", int'(sample_out), m_sample);
    check("sample_valid", int'(sample_valid), m_valid);
    check("wrap", int'(wrap), m_wrap);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    #2;
    m_phase = 0; m_sample = 0; m_valid = 0; m_wrap = 0; m_wave = 0;
    check("rst_sample", int'(sample_out), 0);
    check("rst_valid", int'(sample_valid), 0);
    check("rst_wrap", int'(wrap), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  initial begin
    do_reset();
    phase_inc = 24'h0ABCDE;
    waveform_in = 2'b10;
    for (int i = 0; i < 6; i++) step(1, 1, 0);
    do_reset();
    waveform_in = 2'b00;
    phase_inc = 24'h100000;
    step(1, 1, 0);
    check("first_sample", int'(sample_out), 'hFFF);
    check("first_valid", int'(sample_valid), 1);
    check("first_wrap", int'(wrap), 0);
    step(1, 0, 0);
    check("valid_drops", int'(sample_valid), 0);
    waveform_in = 2'b10;
    step(1, 0, 1);
    for (int k = 0; k < 17; k++) begin
      step(1, 1, 0);
      check("saw", int'(sample_out), (k * 'h100) % 'h1000);
      check("saw_wrap", int'(wrap), (k == 15) ? 1 : 0);
    end
    waveform_in = 2'b01;
    step(1, 0, 1);
    for (int k = 0; k < 16; k++) begin
      step(1, 1, 0);
      check("tri", int'(sample_out), (k < 8) ? k * 'h200 : 'hFFF - (k - 8) * 'h200);
    end
    waveform_in = 2'b00;
    step(1, 0, 1);
    for (int k = 0; k < 16; k++) begin
      step(1, 1, 0);
      check("square", int'(sample_out), (k < 8) ? 'hFFF : 0);
    end
    waveform_in = 2'b11;
    step(1, 0, 1);
    for (int k = 0; k < 5; k++) begin
      step(1, 1, 0);
      check("rsvd", int'(sample_out), 'h800);
    end
    waveform_in = 2'b10;
    step(1, 0, 1);
    for (int k = 0; k < 3; k++) step(1, 1, 0);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 0);
      check("hold_sample", int'(sample_out), 'h200);
      check("hold_valid", int'(sample_valid), 0);
    end
    step(1, 1, 0);
    check("after_hold", int'(sample_out), 'h300);
    step(1, 1, 1);
    check("sync_no_valid", int'(sample_valid), 0);
    step(1, 1, 0);
    check("sync_phase0", int'(sample_out), 0);
    phase_inc = 24'h0;
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 0);
      check("inc0_const", int'(sample_out), 'h100);
      check("inc0_nowrap", int'(wrap), 0);
    end
    phase_inc = 24'h100000;
    waveform_in = 2'b00;
    step(1, 0, 1);
    for (int k = 0; k < 4; k++) step(1, 1, 0);
    waveform_in = 2'b10;
    step(1, 1, 0);
`ifdef WAVE_SYNC_SWITCH_EN
    check("switch_deferred", int'(sample_out), 'hFFF);
`else
    check("switch_immediate", int'(sample_out), 'h400);
`endif
    for (int k = 5; k < 16; k++) step(1, 1, 0);
    step(1, 1, 0);
    check("switch_post_wrap", int'(sample_out), 0);
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 15) == 0) waveform_in = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 20) == 0)
        case ($urandom_range(0, 3))
          0: phase_inc = 24'h0;
          1: phase_inc = 24'h800000 + 24'($urandom_range(0, 'h7FFFFF));
          default: phase_inc = 24'($urandom_range(0, 'h3FFFF));
        endcase
      if ($urandom_range(0, 499) == 0) do_reset();
      else step($urandom_range(0, 9) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 40) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wave_osc.md
Name: wave_osc

Overview:
- Phase-accumulator oscillator directly downstream of the waveform selector.
- Consumes the 2-bit waveform code (00 square, 01 triangle, 10 sawtooth) plus a tuning word, and produces one unsigned sample per sample tick.
- Its output feeds the mixer/DAC stage of the synth.
- Registered outputs, one-cycle latency from tick to sample.

Parameters:
- PHASE_W, 24, phase accumulator width; phase_inc width.
- OUT_W, 12, sample width (unsigned, full scale 0..2^OUT_W-1); must satisfy OUT_W <= PHASE_W-1.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- ena  input  1  global enable; when low, all state holds and no samples are produced
- waveform_in  input  2  waveform code from the selector
- phase_inc  input  PHASE_W  tuning word added to the phase on each tick
- sample_tick  input  1  single-cycle sample-rate strobe
- phase_rst  input  1  synchronous hard-sync; clears the phase
- sample_out  output  OUT_W  current sample
- sample_valid  output  1  one-cycle pulse when sample_out updates
- wrap  output  1  one-cycle pulse when the phase overflows

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high. While rst is high: phase=0, sample_out=0, sample_valid=0, wrap=0, active wave=00.
- Hold: with ena=0, phase and sample_out hold, and sample_valid and wrap are 0. Ticks arriving while ena=0 are dropped, not queued.
- Tick (ena & sample_tick & !phase_rst), all updated on the same edge:
  - sample_out <= shape(active_wave, phase), using the pre-increment phase.
  - phase <= (phase + phase_inc) mod 2^PHASE_W.
  - wrap <= carry-out of that addition.
  - sample_valid <= 1.
  - sample_out and sample_valid are therefore visible one cycle after the tick.
- Non-tick cycles: sample_valid and wrap return to 0. sample_out holds its last value.
- Hard sync (ena & phase_rst): phase <= 0; sample_valid=0 and wrap=0 that cycle. phase_rst has priority over a simultaneous sample_tick, and that tick is consumed with no sample.
- Shape function. Let m = phase[PHASE_W-1] and top = phase[PHASE_W-1 -: OUT_W].
  - Square (00): m ? 0 : all-ones.
  - Sawtooth (10): top.
  - Triangle (01): let r = phase[PHASE_W-2 -: OUT_W]; output m ? ~r : r.
  - 11 (reserved): constant mid-scale 2^(OUT_W-1).
- Boundary cases:
  - phase_inc=0: constant output, valid still pulses each tick, and wrap never fires.
  - phase_inc changes take effect on the next tick. No per-tick phase correction is applied.
  - Any value of phase_inc is legal. Values of 2^(PHASE_W-1) or more alias, and are not clamped.
  - Reset asserted mid-operation clears everything asynchronously. The first tick after release yields shape(00, 0) = all-ones.

Optional Feature:
- Macro: WAVE_SYNC_SWITCH_EN.
- When defined:
  - active_wave is a register loaded from waveform_in only on a tick that produces wrap=1, or on phase_rst.
  - The new waveform therefore first appears on the sample computed from the wrapped phase, i.e. the next tick. This gives click-free switching at period boundaries.
- When undefined: active_wave = waveform_in, sampled at each tick, so switches take effect immediately.

Decomposition:
- synth_pkg holds:
  - waveform code enum: WAVE_SQUARE=2'b00, WAVE_TRIANGLE=2'b01, WAVE_SAWTOOTH=2'b10, WAVE_RSVD=2'b11;
  - default PHASE_W/OUT_W constants.
- One combinational sub-module, wave_shaper, implements shape(wave, phase) over (PHASE_W, OUT_W).
- wave_osc holds the accumulator, the active_wave register and the output registers.

Test Plan:
- Reset/first sample: assert rst mid-run, release, ena=1, waveform=00, phase_inc=0x100000, one tick -> sample_out=0xFFF, sample_valid high exactly one cycle after the tick, wrap=0.
- Sawtooth: waveform=10, phase_inc=0x100000, 17 ticks -> samples 0x000,0x100,...,0xF00,0x000. wrap pulses on the cycle after the 16th tick only.
- Triangle: waveform=01, same increment -> 0x000,0x200,...,0xE00, then 0xFFF,0xDFF,...,0x1FF.
- Square and reserved code: square gives 8x 0xFFF then 8x 0x000. waveform=11 gives a constant 0x800.
- Hold/sync: ena=0 with ticks -> no valid, sample_out frozen. phase_rst coincident with a tick -> no valid, next tick samples phase 0.
- WAVE_SYNC_SWITCH_EN: change 00->10 mid-period -> square continues until the wrap tick, and the first post-wrap sample is 0x000 sawtooth. Without the macro, the switch is visible on the very next sample.
